// File: rtl/i2s_sample_fifo_if.sv
// Stream bundle between the I2S capture stage, the sample FIFO and its consumer.
interface i2s_sample_fifo_if #(
  parameter int unsigned DATA_W = 24
) ();
  logic [DATA_W-1:0] left_i;
  logic [DATA_W-1:0] right_i;
  logic              ready_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [DATA_W-1:0] m_left_o;
  logic [DATA_W-1:0] m_right_o;

  modport master (
    output left_i, right_i, ready_i, m_ready_i,
    input  m_valid_o, m_left_o, m_right_o
  );

  modport slave (
    input  left_i, right_i, ready_i, m_ready_i,
    output m_valid_o, m_left_o, m_right_o
  );
endinterface

// File: rtl/i2s_sample_fifo.sv
// Stereo-pair FIFO between I2S capture and a valid/ready consumer, registered output stage.
// Optional drop counter ovf_cnt_o is enabled by defining I2S_SAMPLE_FIFO_OVF_CNT_EN.
module i2s_sample_fifo #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  i2s_sample_fifo_if.slave       bus,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   overflow_o,
  input  logic                   clear_ovf_i
`ifdef I2S_SAMPLE_FIFO_OVF_CNT_EN
  ,
  output logic [15:0]            ovf_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned PW = 2 * DATA_W;

  logic [PW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [LW-1:0]     resident;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic              pop, push, drop;

  // Output stage reloads from entries already written before this edge, so a
  // fresh push reaches the output one cycle after it lands in memory.
  always_comb begin
    pop      = valid_q & bus.m_ready_i;
    push     = bus.ready_i & (~full_q | pop);
    drop     = bus.ready_i & full_q & ~pop;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    full_d   = (level_d == LW'(DEPTH));
    empty_d  = (level_d == '0);
    ovf_d    = drop | (ovf_q & ~clear_ovf_i);
    resident = level_q - LW'(pop);
    valid_d  = (resident != '0);
    left_d   = left_q;
    right_d  = right_q;
    if (valid_d) begin
      {left_d, right_d} = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      left_q   <= '0;
      right_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      left_q   <= left_d;
      right_q  <= right_d;
    end
  end

  // Storage array carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem_q[wr_ptr_q] <= {bus.left_i, bus.right_i};
    end
  end

`ifdef I2S_SAMPLE_FIFO_OVF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating drop counter; a drop in the clearing cycle still counts.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_ovf_i) begin
      cnt_d = 16'(drop);
    end else if (drop && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ovf_cnt_o = cnt_q;
`endif

  assign bus.m_valid_o = valid_q;
  assign bus.m_left_o  = left_q;
  assign bus.m_right_o = right_q;
  assign level_o       = level_q;
  assign full_o        = full_q;
  assign empty_o       = empty_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Self-checking bench for i2s_sample_fifo against a queue-based reference model.
module tb_i2s_sample_fifo;

  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       ovf;
`ifdef I2S_SAMPLE_FIFO_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  i2s_sample_fifo_if #(.DATA_W(DW)) bus ();

  i2s_sample_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .level_o     (level),
    .full_o      (full),
    .empty_o     (empty),
    .overflow_o  (ovf),
    .clear_ovf_i (clr)
`ifdef I2S_SAMPLE_FIFO_OVF_CNT_EN
    ,
    .ovf_cnt_o   (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    int            e;
  } ent_t;

  ent_t q[$];
  int   edge_n   = 0;
  logic m_ovf    = 1'b0;
  int   m_cnt    = 0;
  logic m_valid  = 1'b0;
  logic zero_chk = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a pair is visible on the output once it was stored at an earlier edge.
  task automatic model_edge();
    logic p, f, d;
    ent_t n;
    edge_n++;
    if (rst) begin
      q.delete();
      m_ovf    = 1'b0;
      m_cnt    = 0;
      zero_chk = 1'b1;
    end else begin
      p = m_valid && bus.m_ready_i;
      f = (q.size() == DEPTH);
      d = 1'b0;
      if (p) void'(q.pop_front());
      if (bus.ready_i) begin
        if (!f || p) begin
          n.l = bus.left_i;
          n.r = bus.right_i;
          n.e = edge_n;
          q.push_back(n);
        end else begin
          d = 1'b1;
        end
      end
      m_ovf = d || (m_ovf && !clr);
      if (clr) m_cnt = d ? 1 : 0;
      else if (d && m_cnt < 65535) m_cnt++;
    end
    m_valid = (q.size() > 0) && (q[0].e < edge_n);
    if (m_valid) zero_chk = 1'b0;
  endtask

  task automatic compare();
    chk("m_valid", 64'(bus.m_valid_o), 64'(m_valid));
    chk("level", 64'(level), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("overflow", 64'(ovf), 64'(m_ovf));
    if (m_valid) begin
      chk("m_left", 64'(bus.m_left_o), 64'(q[0].l));
      chk("m_right", 64'(bus.m_right_o), 64'(q[0].r));
    end else if (zero_chk) begin
      chk("m_left_rst", 64'(bus.m_left_o), 64'd0);
      chk("m_right_rst", 64'(bus.m_right_o), 64'd0);
    end
`ifdef I2S_SAMPLE_FIFO_OVF_CNT_EN
    chk("ovf_cnt", 64'(ovf_cnt), 64'(m_cnt));
`endif
  endtask

  task automatic cyc(input logic rdy, input logic [DW-1:0] l, input logic [DW-1:0] r,
                     input logic mr, input logic c);
    bus.ready_i   = rdy;
    bus.left_i    = l;
    bus.right_i   = r;
    bus.m_ready_i = mr;
    clr           = c;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom);
  endfunction

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    bus.ready_i = 1'b0;
    bus.left_i = '0;
    bus.right_i = '0;
    bus.m_ready_i = 1'b0;
    repeat (2) cyc(1'b1, rnd(), rnd(), 1'b1, 1'b0);
    rst = 1'b0;
    cyc(1'b0, '0, '0, 1'b0, 1'b0);

    // Single push latency and values
    cyc(1'b1, 24'h123456, 24'hABCDEF, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    chk("single_left", 64'(bus.m_left_o), 64'h123456);
    chk("single_right", 64'(bus.m_right_o), 64'hABCDEF);
    chk("single_level", 64'(level), 64'd1);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Fill, drop one, clear flag, push+pop at full, drain
    for (int i = 1; i <= 16; i++) cyc(1'b1, DW'(i), DW'(24'h800000 + i), 1'b0, 1'b0);
    cyc(1'b1, 24'hDEAD01, 24'hBEEF01, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    chk("full_flag", 64'(full), 64'd1);
    chk("ovf_flag", 64'(ovf), 64'd1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    cyc(1'b1, 24'h0A0A0A, 24'h0B0B0B, 1'b1, 1'b0);
    chk("fullpp_level", 64'(level), 64'd16);
    chk("fullpp_ovf", 64'(ovf), 64'd0);
    repeat (20) cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Drop counter: three drops, clear, then clear together with a drop
    for (int i = 0; i < 16; i++) cyc(1'b1, rnd(), rnd(), 1'b0, 1'b0);
    repeat (3) cyc(1'b1, rnd(), rnd(), 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    cyc(1'b1, rnd(), rnd(), 1'b0, 1'b1);
    chk("clr_drop_ovf", 64'(ovf), 64'd1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);

    // Reset mid-stream at level 5, then a fresh push
    rst = 1'b1;
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b1, rnd(), rnd(), 1'b0, 1'b0);
    chk("pre_rst_level", 64'(level), 64'd5);
    rst = 1'b1;
    cyc(1'b1, rnd(), rnd(), 1'b1, 1'b0);
    rst = 1'b0;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_valid", 64'(bus.m_valid_o), 64'd0);
    cyc(1'b1, 24'h123456, 24'hABCDEF, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    chk("rst_push_left", 64'(bus.m_left_o), 64'h123456);

    // Backpressure: 1000 sparse pushes against random consumer ready
    for (int k = 0; k < 1000; k++) begin
      for (int j = 0; j < 64; j++) begin
        cyc(j == 0, rnd(), rnd(), 1'($urandom), 1'b0);
      end
    end
    chk("bp_ovf", 64'(ovf), 64'd0);

    // Random mixed traffic including pops on empty and clears
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom % 3) != 0, rnd(), rnd(), 1'($urandom), ($urandom % 32) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_sample_fifo.md
I2S_SAMPLE_FIFO -- requirements
Module: i2s_sample_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 24: width of each channel sample.
REQ-002 SHALL have parameter DEPTH, default 16: number of stereo pairs stored; power of two, minimum 4.
REQ-003 SHALL have these ports, clock and reset first (the I2S capture stage drives `left_i`, `right_i` and `ready_i`):
- clk_i  in  1  system clock; one clock, all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- left_i  in  DATA_W  left sample from the capture stage.
- right_i  in  DATA_W  right sample from the capture stage.
- ready_i  in  1  one-cycle strobe: the pair on `left_i`/`right_i` is complete.
- m_valid_o  out  1  the output pair is valid.
- m_ready_i  in  1  the consumer accepts the output pair.
- m_left_o  out  DATA_W  head-of-queue left sample.
- m_right_o  out  DATA_W  head-of-queue right sample.
- level_o  out  $clog2(DEPTH)+1  number of pairs held, including the output pair.
- full_o  out  1  level_o == DEPTH.
- empty_o  out  1  level_o == 0.
- overflow_o  out  1  sticky flag: a pair was dropped.
- clear_ovf_i  in  1  clears overflow_o (and ovf_cnt_o when present).

Function
REQ-004 Push: on ready_i=1 with full_o=0, SHALL store {left_i, right_i} as one entry; both channels are always written together.
REQ-005 Overflow: on ready_i=1 with full_o=1 and no pop in the same cycle, SHALL drop the new pair, leave stored data unchanged, and set overflow_o on the next cycle.
REQ-006 Pop: a transfer occurs when m_valid_o=1 and m_ready_i=1; the next entry SHALL be presented on the following cycle, or m_valid_o SHALL drop if none remains.
REQ-007 Push and pop in the same cycle while full SHALL accept the push; level_o is unchanged and no overflow occurs.
REQ-008 Push and pop in the same cycle at any other level SHALL leave level_o unchanged.
REQ-009 Latency: a push into an empty FIFO at edge N SHALL give m_valid_o=1, with that data on m_left_o/m_right_o, after edge N+1.
REQ-010 Output stage: m_left_o, m_right_o and m_valid_o SHALL be registered.
REQ-011 Output hold: while m_valid_o=1 and m_ready_i=0, m_left_o and m_right_o SHALL hold stable.
REQ-012 Read and write pointers SHALL wrap modulo DEPTH.
REQ-013 Level tracking: level_o SHALL change by +1 on push only, -1 on pop only, and 0 otherwise; it never exceeds DEPTH and never goes negative.
REQ-014 Data ordering: pairs SHALL leave in arrival order, with left and right never swapped or split.
REQ-015 A pop attempted when m_valid_o=0 SHALL be ignored.
REQ-016 Clear: clear_ovf_i=1 SHALL clear overflow_o on the next cycle.
REQ-017 If clear_ovf_i=1 and an overflow occur in the same cycle, the flag SHALL end set (set wins).

Reset
REQ-018 While rst_i=1, at each clock edge the block SHALL set:
- m_valid_o=0, m_left_o=0, m_right_o=0;
- level_o=0, empty_o=1, full_o=0, overflow_o=0;
- both pointers to 0.
REQ-019 Reset mid-operation SHALL discard all stored pairs; pushes or pops presented during reset SHALL be ignored.
REQ-020 The memory array itself needs no reset.

Configuration
REQ-021 Macro I2S_SAMPLE_FIFO_OVF_CNT_EN defined: SHALL add output ovf_cnt_o[15:0], which increments by 1 per dropped pair, saturates at 16'hFFFF, and clears on rst_i or clear_ovf_i.
REQ-022 In the clear-and-drop cycle, ovf_cnt_o SHALL become 1.
REQ-023 Macro not defined: the ovf_cnt_o port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-024 Single push: after reset, one ready_i with L=24'h123456, R=24'hABCDEF -> one cycle later m_valid_o=1 with exactly those values; level_o=1.
REQ-025 Fill and overflow: 16 pushes with m_ready_i=0 -> full_o=1; a 17th push -> overflow_o=1, data unchanged; draining returns pairs 1..16 in order.
REQ-026 Full with simultaneous push and pop: push with m_ready_i=1 while full -> level_o stays 16, overflow_o stays 0, new pair appears last.
REQ-027 Backpressure: m_ready_i toggled pseudo-randomly against 1000 pushes spaced 64 cycles apart -> all pairs received in order, no overflow.
REQ-028 Reset mid-stream: rst_i pulsed with level_o=5 -> next cycle level_o=0, m_valid_o=0, outputs zero; a subsequent push behaves as in REQ-024.
REQ-029 With I2S_SAMPLE_FIFO_OVF_CNT_EN: 3 drops -> ovf_cnt_o=3; clear_ovf_i -> 0; clear in the same cycle as a drop -> ovf_cnt_o=1, overflow_o=1.
